// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding and the
// power-on start addresses of the four program slots.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int NUM_SLOTS   = 4;
   localparam int SLOT_STRIDE = 64;

   // Slot n starts at n*64; callers truncate to their address width.
   function automatic int def_addr(input int slot);
      return slot * SLOT_STRIDE;
   endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host/core-facing signal bundle of the run controller; the host side is the
// master, the controller is the slave.
interface run_ctrl_if #(
   parameter int D  = 8,
   parameter int CW = 16
);
   logic          req;
   logic [1:0]    prog_sel;
   logic          cfg_we;
   logic [1:0]    cfg_idx;
   logic [D-1:0]  cfg_addr;
   logic          halt;
   logic          core_rst;
   logic          start_ld;
   logic [D-1:0]  start_addr;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycles;

   modport master (
      output req, prog_sel, cfg_we, cfg_idx, cfg_addr, halt,
      input  core_rst, start_ld, start_addr, busy, done, timeout, cycles
   );

   modport slave (
      input  req, prog_sel, cfg_we, cfg_idx, cfg_addr, halt,
      output core_rst, start_ld, start_addr, busy, done, timeout, cycles
   );
endinterface

// File: rtl/run_ctrl_start_tbl.sv
// Four-entry start-address register table with a single write port and a
// combinational read mux driven by the latched slot select.
module start_tbl
   import run_ctrl_pkg::*;
#(
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [1:0]   idx,
   input  logic [D-1:0] wdata,
   input  logic [1:0]   sel,
   output logic [D-1:0] rdata
);

   logic [D-1:0] slot_reg [NUM_SLOTS];

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (reset) begin
               slot_reg[gi] <= D'(def_addr(gi));
            end else if (we && (idx == 2'(gi))) begin
               slot_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = slot_reg[sel];

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences a processor core through load, run and done,
// counting run cycles and ending the run on halt, abort or cycle limit.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int D      = 8,
   parameter int CW     = 16,
   parameter int MAXCYC = 4000
) (
   input  logic     clk,
   input  logic     reset,
   run_ctrl_if.slave bus
);

   localparam logic [CW-1:0] LAST_CYC = CW'(MAXCYC - 1);

   state_t        state_reg, state_next;
   logic [1:0]    sel_reg, sel_next;
   logic [CW-1:0] cycles_reg, cycles_next;
   logic          timeout_reg, timeout_next;
   logic          tbl_we;
   logic [D-1:0]  start_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         sel_reg     <= 2'd0;
         cycles_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sel_reg     <= sel_next;
         cycles_reg  <= cycles_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      sel_next     = sel_reg;
      cycles_next  = cycles_reg;
      timeout_next = timeout_reg;
      tbl_we       = 1'b0;
      case (state_reg)
         IDLE: begin
            // A write racing the run start on the selected slot is dropped so
            // the run keeps the address it was launched with.
            tbl_we = bus.cfg_we && !(bus.req && (bus.cfg_idx == bus.prog_sel));
            if (bus.req) begin
               sel_next     = bus.prog_sel;
               cycles_next  = '0;
               timeout_next = 1'b0;
               state_next   = LOAD;
            end
         end
         LOAD: begin
            state_next = bus.req ? RUN : IDLE;
         end
         RUN: begin
            cycles_next = cycles_reg + 1'b1;
            if (!bus.req) begin
               state_next = IDLE;
            end else if (bus.halt) begin
               state_next = DONE;
            end else if (cycles_reg == LAST_CYC) begin
               state_next   = DONE;
               timeout_next = 1'b1;
            end
         end
         DONE: begin
            if (!bus.req) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   start_tbl #(.D(D)) u_tbl (
      .clk   (clk),
      .reset (reset),
      .we    (tbl_we),
      .idx   (bus.cfg_idx),
      .wdata (bus.cfg_addr),
      .sel   (sel_reg),
      .rdata (start_addr)
   );

   assign bus.core_rst   = (state_reg != RUN);
   assign bus.start_ld   = (state_reg == LOAD);
   assign bus.busy       = (state_reg == LOAD) || (state_reg == RUN);
   assign bus.done       = (state_reg == DONE);
   assign bus.timeout    = timeout_reg;
   assign bus.cycles     = cycles_reg;
   assign bus.start_addr = start_addr;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: each run pushes its expected outcome when
// launched and pops it for comparison once the controller leaves LOAD/RUN.
module tb_run_ctrl;

   localparam int D    = 8;
   localparam int CW   = 16;
   localparam int MAXC = 10;

   typedef struct {
      logic [D-1:0]  addr;
      logic [CW-1:0] cycles;
      logic          done;
      logic          timeout;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   exp_t sb_q[$];
   logic [D-1:0] tbl_model [4];

   run_ctrl_if #(.D(D), .CW(CW)) bus ();

   run_ctrl #(.D(D), .CW(CW), .MAXCYC(MAXC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      tbl_model[0] = 8'd0;
      tbl_model[1] = 8'd64;
      tbl_model[2] = 8'd128;
      tbl_model[3] = 8'd192;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, ".core_rst"}, 32'(bus.core_rst), 32'd1);
      check_val({tag, ".start_ld"}, 32'(bus.start_ld), 32'd0);
      check_val({tag, ".busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, ".done"}, 32'(bus.done), 32'd0);
      check_val({tag, ".timeout"}, 32'(bus.timeout), 32'd0);
      check_val({tag, ".cycles"}, 32'(bus.cycles), 32'd0);
      check_val({tag, ".start_addr"}, 32'(bus.start_addr), 32'd0);
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [D-1:0] addr);
      bus.cfg_we   = 1'b1;
      bus.cfg_idx  = idx;
      bus.cfg_addr = addr;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      tbl_model[idx] = addr;
      $display("cfg write slot=%0d addr=%0h", idx, addr);
   endtask

   // halt_at/drop_at: RUN cycle (1-based) on which halt is raised or req dropped; 0 = never.
   task automatic run_job(input logic [1:0] sel, input int halt_at, input int drop_at,
                          input bit wr_in_run, input bit coin_wr);
      exp_t e;
      exp_t got;
      int   k;
      bit   fin;
      e.addr = tbl_model[sel];
      if (drop_at > 0 && (halt_at == 0 || drop_at < halt_at) && drop_at <= MAXC) begin
         e.cycles = CW'(drop_at); e.done = 1'b0; e.timeout = 1'b0;
      end else if (halt_at > 0 && halt_at <= MAXC) begin
         e.cycles = CW'(halt_at); e.done = 1'b1; e.timeout = 1'b0;
      end else begin
         e.cycles = CW'(MAXC); e.done = 1'b1; e.timeout = 1'b1;
      end
      sb_q.push_back(e);

      bus.req      = 1'b1;
      bus.prog_sel = sel;
      if (coin_wr) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_idx  = sel;
         bus.cfg_addr = 8'h77;
      end
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      check_val("load.start_ld", 32'(bus.start_ld), 32'd1);
      check_val("load.busy", 32'(bus.busy), 32'd1);
      check_val("load.core_rst", 32'(bus.core_rst), 32'd1);
      check_val("load.start_addr", 32'(bus.start_addr), 32'(e.addr));
      check_val("load.cycles", 32'(bus.cycles), 32'd0);
      check_val("load.timeout", 32'(bus.timeout), 32'd0);

      @(posedge clk); #1;
      check_val("run1.core_rst", 32'(bus.core_rst), 32'd0);
      check_val("run1.start_ld", 32'(bus.start_ld), 32'd0);
      k   = 1;
      fin = 1'b0;
      while (!fin && k < 40) begin
         bus.halt = (k == halt_at);
         if (k == drop_at) bus.req = 1'b0;
         if (wr_in_run && k == 2) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_idx  = 2'd1;
            bus.cfg_addr = 8'h55;
         end
         @(posedge clk); #1;
         bus.halt   = 1'b0;
         bus.cfg_we = 1'b0;
         if (!bus.busy) fin = 1'b1;
         else k++;
      end
      check_val("run.ended_in_bound", 32'(fin), 32'd1);

      got = sb_q.pop_front();
      check_val("end.done", 32'(bus.done), 32'(got.done));
      check_val("end.timeout", 32'(bus.timeout), 32'(got.timeout));
      check_val("end.cycles", 32'(bus.cycles), 32'(got.cycles));
      check_val("end.core_rst", 32'(bus.core_rst), 32'd1);
      $display("run sel=%0d addr=%0h cycles=%0d done=%0b timeout=%0b", sel, got.addr,
               bus.cycles, bus.done, bus.timeout);

      if (got.done) begin
         @(posedge clk); #1;
         check_val("hold.done", 32'(bus.done), 32'd1);
         check_val("hold.cycles", 32'(bus.cycles), 32'(got.cycles));
         check_val("hold.timeout", 32'(bus.timeout), 32'(got.timeout));
         bus.req = 1'b0;
         @(posedge clk); #1;
         check_val("release.done", 32'(bus.done), 32'd0);
         check_val("release.busy", 32'(bus.busy), 32'd0);
         check_val("release.cycles", 32'(bus.cycles), 32'(got.cycles));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_reset();
      reset        = 1'b1;
      bus.req      = 1'b0;
      bus.prog_sel = 2'd0;
      bus.cfg_we   = 1'b0;
      bus.cfg_idx  = 2'd0;
      bus.cfg_addr = '0;
      bus.halt     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      run_job(2'd2, 5, 0, 1'b0, 1'b0);    // halt on 5th RUN cycle
      run_job(2'd0, 0, 0, 1'b0, 1'b0);    // cycle limit
      run_job(2'd3, 10, 0, 1'b0, 1'b0);   // halt coincides with limit
      run_job(2'd1, 0, 3, 1'b0, 1'b0);    // abort on 3rd RUN cycle
      run_job(2'd3, 1, 0, 1'b0, 1'b0);    // halt on first RUN cycle

      cfg_write(2'd1, 8'h20);
      run_job(2'd1, 2, 0, 1'b1, 1'b0);    // write during RUN must be ignored
      run_job(2'd1, 4, 0, 1'b0, 1'b0);

      // Reset during RUN
      bus.req      = 1'b1;
      bus.prog_sel = 2'd3;
      repeat (3) @(posedge clk);
      #1;
      check_val("midrun.busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      model_reset();
      check_reset_state("midrun_reset");
      reset   = 1'b0;
      bus.req = 1'b0;
      @(posedge clk); #1;
      $display("reset during run sel=3");

      run_job(2'd1, 6, 0, 1'b0, 1'b0);    // table back to defaults
      run_job(2'd2, 3, 0, 1'b0, 1'b1);    // racing write to selected slot

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter D, default 8, program counter width.
REQ-002 SHALL have parameter CW, default 16, cycle-counter width.
REQ-003 SHALL have parameter MAXCYC, default 4000, RUN-cycle timeout limit; 1 <= MAXCYC <= 2**CW-1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  host run request, level; held high for the whole run.
REQ-007 prog_sel  input  2  program slot selector, sampled in IDLE when req rises.
REQ-008 cfg_we  input  1  start-address table write enable.
REQ-009 cfg_idx  input  2  table slot to write.
REQ-010 cfg_addr  input  D  start address to write.
REQ-011 halt  input  1  core halt indication (all-ones machine code fetched).
REQ-012 core_rst  output  1  holds processor core in reset.
REQ-013 start_ld  output  1  one-cycle pulse; PC loads start_addr.
REQ-014 start_addr  output  D  selected slot's start address.
REQ-015 busy  output  1  high in LOAD and RUN.
REQ-016 done  output  1  run finished, held until req falls.
REQ-017 timeout  output  1  run ended by cycle limit, not halt.
REQ-018 cycles  output  CW  RUN cycles of the current or last run.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-020 IDLE: core_rst=1, busy=0, done=0; on req=1, latch prog_sel and go to LOAD next cycle.
REQ-021 LOAD (exactly 1 cycle): core_rst=1, start_ld=1, busy=1, cycles cleared to 0, timeout cleared to 0; go to RUN.
REQ-022 RUN: core_rst=0, busy=1; cycles increments by 1 every RUN cycle, including the exit cycle.
REQ-023 RUN -> DONE when halt=1; timeout stays 0.
REQ-024 RUN -> DONE when cycles+1 == MAXCYC and halt=0; timeout set to 1 on entry to DONE.
REQ-025 If halt and the limit coincide, halt wins: timeout=0.
REQ-026 DONE: done=1, core_rst=1, busy=0; cycles and timeout frozen; go to IDLE when req=0.
REQ-027 If req=0 in LOAD or RUN, go to IDLE next cycle (abort): done never asserts; cycles holds the partial count.
REQ-028 start_ld SHALL be high only in LOAD; start_addr = table[latched prog_sel] in all states.
REQ-029 Table SHALL hold 4 entries of D bits; a cfg_we write takes effect in the following cycle.
REQ-030 cfg_we SHALL be honoured only in IDLE; writes in LOAD, RUN and DONE are ignored.
REQ-031 A cfg_we write to the slot being selected in the same IDLE cycle that req rises SHALL not affect that run; the old value is used.
REQ-032 cycles SHALL never wrap; the limit guarantees this.

Reset
REQ-033 reset=1 SHALL force IDLE at the next edge, from any state; reset mid-run is an abort.
REQ-034 Reset values: core_rst=1, start_ld=0, busy=0, done=0, timeout=0, cycles=0, latched sel=0.
REQ-035 Table reset values: slot0=0, slot1=64, slot2=128, slot3=192, truncated to D bits.

Structure
REQ-036 FSM state enum and default table addresses SHALL live in the shared project package.
REQ-037 SHALL contain one sub-module, start_tbl: the 4-entry register table with write port and read mux.
REQ-038 SHALL contain no combinational path from req to start_ld or core_rst; all outputs are registered or state-decoded.

Verification
REQ-039 Reset, then req=1 with prog_sel=2 -> LOAD 1 cycle, start_ld=1, start_addr=128; core_rst falls the next cycle.
REQ-040 Run with halt=1 on the 5th RUN cycle -> done=1, cycles=5, timeout=0; req=0 -> IDLE the next cycle, done=0.
REQ-041 MAXCYC=10, halt never asserted -> DONE after 10 RUN cycles, cycles=10, timeout=1, core_rst=1.
REQ-042 MAXCYC=10, halt=1 on the 10th RUN cycle -> done=1, timeout=0.
REQ-043 Drop req on the 3rd RUN cycle -> IDLE, done stays 0, cycles=3; reset on a RUN cycle -> all outputs at reset values.
REQ-044 In IDLE write cfg_idx=1, cfg_addr=0x20 -> next run with prog_sel=1 loads 0x20; the same write during RUN -> table unchanged.
